// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches, buffers in-order
// responses with their PCs, and discards responses made stale by a redirect.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pcplus4
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = CW + 1;
    localparam logic [0:0]      RUN     = 1'b0;
    localparam logic [0:0]      DRAIN   = 1'b1;
    localparam logic [IW-1:0]   DEPTH_W = IW'(DEPTH);
    localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

    logic [0:0]      state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [CW-1:0]   occupancy_reg, occupancy_next;
    logic [PW-1:0]   head_reg, head_next, tail_reg, tail_next;
    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic            req_fire, rsp_fire, push, pop;
    logic [IW-1:0]   in_use;
    logic [XLEN-1:0] target_pc;

    assign target_pc      = redirect_pc & ~XLEN'(3);
    assign in_use         = {1'b0, outstanding_reg} + {1'b0, occupancy_reg};
    // Gated by reset so the request drops the instant reset asserts.
    assign imem_req_valid = reset && (state_reg == RUN) && (in_use < DEPTH_W);
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (outstanding_reg != '0);
    assign push           = rsp_fire && (state_reg == RUN) && !redirect;
    assign out_valid      = (occupancy_reg != '0);
    assign pop            = out_valid && out_ready;
    assign out_instr      = out_valid ? instr_mem[head_reg] : '0;
    assign out_pc         = out_valid ? pc_mem[head_reg] : '0;
    assign out_pcplus4    = out_valid ? pc_mem[head_reg] + FOUR : '0;

    always_comb begin
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_fire);
        fetch_pc_next    = req_fire ? fetch_pc_reg + FOUR : fetch_pc_reg;
        state_next       = state_reg;
        drop_cnt_next    = drop_cnt_reg;
        if (state_reg == DRAIN) begin
            drop_cnt_next = drop_cnt_reg - CW'(rsp_fire);
            if (drop_cnt_next == '0) begin
                state_next = RUN;
            end
        end
        if (redirect) begin
            fetch_pc_next = target_pc;
            // Everything still in flight after this edge belongs to the old path.
            if (state_reg == RUN) begin
                drop_cnt_next = outstanding_next;
                state_next    = (outstanding_next != '0) ? DRAIN : RUN;
            end
        end
    end

    // The next accepted response always belongs to rsp_pc_reg: order is kept.
    always_comb begin
        rsp_pc_next = rsp_pc_reg;
        if (push) begin
            rsp_pc_next = rsp_pc_reg + FOUR;
        end
        if (redirect) begin
            rsp_pc_next = target_pc;
        end
    end

    always_comb begin
        occupancy_next = occupancy_reg + CW'(push) - CW'(pop);
        head_next      = head_reg + PW'(pop);
        tail_next      = tail_reg + PW'(push);
        if (redirect) begin
            occupancy_next = '0;
            head_next      = '0;
            tail_next      = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= RUN;
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            occupancy_reg   <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            occupancy_reg   <= occupancy_next;
            head_reg        <= head_next;
            tail_reg        <= tail_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_reg] <= imem_rsp_data;
            pc_mem[tail_reg]    <= rsp_pc_reg;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences, and a
// randomized run against a stream-level reference model.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, redirect = 1'b0, out_ready = 1'b0;
    logic [31:0] imem_rsp_data = '0, redirect_pc = '0;
    logic        imem_req_valid, out_valid;
    logic [31:0] imem_req_addr, out_instr, out_pc, out_pcplus4;
    logic        b_req_valid, b_out_valid;
    logic [31:0] b_req_addr, b_out_instr, b_out_pc, b_out_pcplus4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pcplus4(out_pcplus4)
    );

    // Same stimulus, start address near the top of the address space.
    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(b_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
        .out_pc(b_out_pc), .out_pcplus4(b_out_pcplus4)
    );

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rv;
        logic [31:0] rd;
        bit          ordy;
        bit          e_rqv;
        logic [31:0] e_addr;
        bit          e_ov;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    vec_t  tv[$];
    mreq_t mq[$];

    function automatic logic [31:0] md(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit rdy, input bit rv, input logic [31:0] rd, input bit ordy,
                       input bit e_rqv, input logic [31:0] e_addr, input bit e_ov, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ordy = ordy;
        v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
        tv.push_back(v);
    endtask

    task automatic drive(input bit rdy, input bit rv, input logic [31:0] rd,
                         input bit redir, input logic [31:0] rpc, input bit ordy);
        @(negedge clk);
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        redirect       = redir;
        redirect_pc    = rpc;
        out_ready      = ordy;
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_instr"}, out_instr, 0);
        chk({tag, "_out_pc"}, out_pc, 0);
        chk({tag, "_out_pcplus4"}, out_pcplus4, 0);
        chk({tag, "_wrap_req_addr"}, b_req_addr, 32'hFFFF_FFF8);
    endtask

    // Reset asserted between edges and released mid-cycle after one edge.
    task automatic do_reset();
        @(negedge clk);
        imem_req_ready = 0; imem_rsp_valid = 0; redirect = 0; out_ready = 0;
        #2 reset = 1'b0;
        #1 chk_cleared("rst");
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_out_pc"}, out_pc, pc);
        chk({tag, "_out_instr"}, out_instr, md(pc));
        chk({tag, "_out_pcplus4"}, out_pcplus4, pc + 32'd4);
        $display("%s deliver pc=%h instr=%h", tag, out_pc, out_instr);
    endtask

    initial begin
        // Streaming: latency-1 memory, always ready, decode always ready.
        add(1, 1, 0, 32'h0,    1, 1, 32'h0,  0, 32'h0);
        add(0, 1, 1, md(0),    1, 1, 32'h4,  0, 32'h0);
        add(0, 1, 1, md(4),    1, 1, 32'h8,  1, 32'h0);
        add(0, 1, 1, md(8),    1, 1, 32'hC,  1, 32'h4);
        add(0, 1, 1, md('hC),  1, 1, 32'h10, 1, 32'h8);
        // Backpressure: decode stalls for 10 cycles, then resumes.
        add(1, 1, 0, 32'h0,    0, 1, 32'h0,  0, 32'h0);
        add(0, 1, 1, md(0),    0, 1, 32'h4,  0, 32'h0);
        add(0, 1, 1, md(4),    0, 1, 32'h8,  1, 32'h0);
        add(0, 1, 1, md(8),    0, 1, 32'hC,  1, 32'h0);
        add(0, 1, 1, md('hC),  0, 0, 32'h0,  1, 32'h0);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0);
        add(0, 1, 0, 32'h0,    1, 0, 32'h0,  1, 32'h0);
        add(0, 1, 0, 32'h0,    1, 1, 32'h10, 1, 32'h4);
        add(0, 1, 1, md('h10), 1, 1, 32'h14, 1, 32'h8);

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst) do_reset();
            drive(tv[i].rdy, tv[i].rv, tv[i].rd, 0, 32'h0, tv[i].ordy);
            chk($sformatf("v%0d_req_valid", i), imem_req_valid, tv[i].e_rqv);
            if (tv[i].e_rqv) begin
                chk($sformatf("v%0d_req_addr", i), imem_req_addr, tv[i].e_addr);
                chk($sformatf("v%0d_wrap_req_addr", i), b_req_addr, tv[i].e_addr + 32'hFFFF_FFF8);
            end
            chk($sformatf("v%0d_out_valid", i), out_valid, tv[i].e_ov);
            if (tv[i].e_ov) begin
                chk($sformatf("v%0d_out_pc", i), out_pc, tv[i].e_pc);
                chk($sformatf("v%0d_out_instr", i), out_instr, md(tv[i].e_pc));
                chk($sformatf("v%0d_out_pcplus4", i), out_pcplus4, tv[i].e_pc + 32'd4);
                chk($sformatf("v%0d_wrap_out_pc", i), b_out_pc, tv[i].e_pc + 32'hFFFF_FFF8);
                chk($sformatf("v%0d_wrap_out_pcplus4", i), b_out_pcplus4, tv[i].e_pc + 32'hFFFF_FFFC);
            end
            $display("vec %0d req_valid=%0b addr=%h out_valid=%0b out_pc=%h wrap_pc=%h",
                     i, imem_req_valid, imem_req_addr, out_valid, out_pc, b_out_pc);
        end

        // Redirect with three requests outstanding.
        do_reset();
        drive(1, 0, 0, 0, 0, 1);           chk("rd_addr0", imem_req_addr, 32'h0);
        drive(1, 0, 0, 0, 0, 1);           chk("rd_addr1", imem_req_addr, 32'h4);
        drive(1, 0, 0, 0, 0, 1);           chk("rd_addr2", imem_req_addr, 32'h8);
        drive(0, 0, 0, 1, 32'h103, 1);     chk("rd_valid_at_redirect", imem_req_valid, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, md(32'(k) * 4), 0, 0, 1);
            chk($sformatf("rd_drain%0d_req_valid", k), imem_req_valid, 0);
            chk($sformatf("rd_drain%0d_out_valid", k), out_valid, 0);
        end
        drive(1, 0, 0, 0, 0, 1);
        chk("rd_resume_valid", imem_req_valid, 1);
        chk("rd_resume_addr", imem_req_addr, 32'h100);
        drive(1, 1, md('h100), 0, 0, 1);   chk("rd_ov_before", out_valid, 0);
        drive(0, 1, md('h104), 0, 0, 1);   chk_out("rd", 32'h100);

        // Redirect coinciding with a response, a request accept and a pop.
        do_reset();
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 1, md(0), 0, 0, 1);
        drive(1, 1, md(4), 1, 32'h200, 1);
        chk_out("col_pop", 32'h0);
        chk("col_stale_req", imem_req_addr, 32'h8);
        drive(1, 1, md(8), 0, 0, 1);
        chk("col_ov_next", out_valid, 0);
        chk("col_drain_req", imem_req_valid, 0);
        drive(1, 0, 0, 0, 0, 1);
        chk("col_resume_addr", imem_req_valid ? imem_req_addr : 32'hFFFF_FFFF, 32'h200);
        drive(1, 1, md('h200), 0, 0, 1);   chk("col_ov_before", out_valid, 0);
        drive(0, 1, md('h204), 0, 0, 1);   chk_out("col", 32'h200);

        // Asynchronous reset pulse while draining.
        do_reset();
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 32'h300, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("ar_drain_req", imem_req_valid, 0);
        #1 reset = 1'b0;
        #1 chk_cleared("ar");
        reset = 1'b1;
        #1 chk("ar_release_req", imem_req_valid, 1);
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 1);
        chk("ar_addr", imem_req_addr, 32'h0);
        drive(1, 0, 0, 0, 0, 1);
        chk("ar_ignored", out_valid, 0);
        chk("ar_first_addr", imem_req_addr, 32'h0);
        drive(1, 1, md(0), 0, 0, 1);
        chk("ar_ov_before", out_valid, 0);
        drive(0, 0, 0, 0, 0, 1);
        chk_out("ar", 32'h0);

        // Randomized run against the stream model.
        do_reset();
        begin
            logic [31:0] exp_req, exp_out, held_pc, held_instr, rpc;
            bit          prev_hold, prev_redir, rdy, ordy, redir, rv;
            logic [31:0] rd;
            int          pops;
            exp_req = 32'h0; exp_out = 32'h0; prev_hold = 0; prev_redir = 0; pops = 0;
            held_pc = '0; held_instr = '0;
            mq.delete();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                rdy   = ($urandom % 4) != 0;
                ordy  = ($urandom % 3) != 0;
                redir = ($urandom % 20) == 0;
                rpc   = $urandom;
                rv    = (mq.size() > 0) && (mq[0].due <= cyc);
                rd    = rv ? md(mq[0].addr) : $urandom;
                drive(rdy, rv, rd, redir, rpc, ordy);
                if (prev_redir) begin
                    chk("rnd_flush", out_valid, 0);
                end else if (prev_hold) begin
                    chk("rnd_hold_valid", out_valid, 1);
                    chk("rnd_hold_pc", out_pc, held_pc);
                    chk("rnd_hold_instr", out_instr, held_instr);
                end
                if (out_valid && ordy) begin
                    chk("rnd_pc", out_pc, exp_out);
                    chk("rnd_instr", out_instr, md(exp_out));
                    chk("rnd_pcplus4", out_pcplus4, exp_out + 32'd4);
                    $display("rnd %0d deliver pc=%h instr=%h", cyc, out_pc, out_instr);
                    exp_out = exp_out + 32'd4;
                    pops++;
                end
                if (imem_req_valid) begin
                    chk("rnd_req_addr", imem_req_addr, exp_req);
                    if (rdy) begin
                        mq.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(1, 4))});
                        exp_req = exp_req + 32'd4;
                        chk("rnd_outstanding_bound", (mq.size() - (rv ? 1 : 0)) <= 4, 1);
                    end
                end
                if (rv) void'(mq.pop_front());
                prev_hold  = out_valid && !ordy && !redir;
                held_pc    = out_pc;
                held_instr = out_instr;
                prev_redir = redir;
                if (redir) begin
                    exp_req = rpc & ~32'h3;
                    exp_out = rpc & ~32'h3;
                end
            end
            chk("rnd_throughput", pops > 200, 1);
        end

        drive(0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
